// File: rtl/sobel_stream_ci_if.sv
// Custom-instruction bus between the CPU (master) and the Sobel streaming
// block (slave).
interface sobel_stream_ci_if;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (output start, ciN, valueA, valueB, input done, result);
  modport slave  (input start, ciN, valueA, valueB, output done, result);
endinterface

// File: rtl/sobel_stream_ci.sv
// Streaming 3x3 Sobel edge detector behind a CPU custom-instruction port:
// four pixels per PUSH, two line buffers, one thresholded edge byte per pixel.
module sobel_stream_ci #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         MAX_WIDTH           = 640,
  parameter int         CNT_W               = 16
) (
  input logic              clock,
  input logic              reset,
  sobel_stream_ci_if.slave ci
);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int WW = ($clog2(MAX_WIDTH + 1) > 10) ? $clog2(MAX_WIDTH + 1) : 10;
  localparam logic [WW-1:0] WIDTH_MAX = WW'(MAX_WIDTH);
  localparam logic [1:0] OP_CONFIG = 2'b00;
  localparam logic [1:0] OP_PUSH   = 2'b01;
  localparam logic [1:0] OP_STATUS = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  function automatic logic signed [10:0] px(input logic [7:0] v);
    px = $signed({3'b000, v});
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    abs11 = v[10] ? 11'(-v) : 11'(v);
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             pix_q, pix_d;
  logic [31:0]            data_q, data_d;
  logic [31:0]            acc_q, acc_d;
  logic [7:0]             thr_q, thr_d;
  logic [WW-1:0]          width_q, width_d;
  logic [CNT_W-1:0]       col_q, col_d, row_q, row_d;
  logic [2:0][2:0][7:0]   win_q, win_d;   // [row top..bottom][col left..right]
  logic [7:0]             line_a_q [MAX_WIDTH];
  logic [7:0]             line_b_q [MAX_WIDTH];

  logic                   accept_s;
  logic [1:0]             op_s;
  logic [9:0]             enc_s;
  logic [AW-1:0]          addr_s;
  logic [7:0]             pix_s, la_s, lb_s, edge_s;
  logic [2:0][2:0][7:0]   win_s;
  logic signed [10:0]     gx_s, gy_s;
  logic [11:0]            mag_s;
  logic                   col_last_s;
  logic                   done_s;
  logic [31:0]            result_s;
  logic                   unused_s;

  assign op_s     = ci.valueB[1:0];
  assign unused_s = ^ci.valueB[31:2];
  assign accept_s = !reset && ci.start && (ci.ciN == customInstructionId) && (state_q == IDLE);
  assign enc_s    = {ci.valueA[25:18], 2'b00};
  assign addr_s   = AW'(col_q);
  assign pix_s    = data_q[{pix_q, 3'b000} +: 8];
  assign la_s     = line_a_q[addr_s];
  assign lb_s     = line_b_q[addr_s];
  assign col_last_s = ((32'(col_q) + 32'd1) == 32'(width_q));

  // Window after shifting in the current pixel's column.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_s[r][0] = win_q[r][1];
      win_s[r][1] = win_q[r][2];
    end
    win_s[0][2] = lb_s;
    win_s[1][2] = la_s;
    win_s[2][2] = pix_s;
  end

  assign gx_s = (px(win_s[0][2]) + (px(win_s[1][2]) <<< 1) + px(win_s[2][2]))
              - (px(win_s[0][0]) + (px(win_s[1][0]) <<< 1) + px(win_s[2][0]));
  assign gy_s = (px(win_s[2][0]) + (px(win_s[2][1]) <<< 1) + px(win_s[2][2]))
              - (px(win_s[0][0]) + (px(win_s[0][1]) <<< 1) + px(win_s[0][2]));
  assign mag_s = {1'b0, abs11(gx_s)} + {1'b0, abs11(gy_s)};
  // The first two rows and columns never have a full neighbourhood.
  assign edge_s = ((mag_s > {4'b0000, thr_q}) && (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2)))
                ? 8'hFF : 8'h00;

  // Command decode, pixel sequencing and counter/window next state.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    data_d  = data_q;
    acc_d   = acc_q;
    thr_d   = thr_q;
    width_d = width_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (op_s)
            OP_CONFIG: begin
              thr_d = ci.valueA[7:0];
              if ((enc_s == 10'd0) || (32'(enc_s) > MAX_WIDTH)) begin
                width_d = WIDTH_MAX;
              end else begin
                width_d = WW'(enc_s);
              end
            end
            OP_PUSH: begin
              state_d = BUSY;
              pix_d   = 2'd0;
              data_d  = ci.valueA;
              acc_d   = 32'd0;
            end
            OP_CLEAR: begin
              col_d = '0;
              row_d = '0;
              win_d = '0;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d[{pix_q, 3'b000} +: 8] = edge_s;
        pix_d = pix_q + 2'd1;
        if (col_last_s) begin
          col_d = '0;
          row_d = (&row_q) ? row_q : row_q + CNT_W'(1);
          win_d = '0;
        end else begin
          col_d = col_q + CNT_W'(1);
          win_d = win_s;
        end
        if (pix_q == 2'd3) begin
          state_d = RESP;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Immediate commands answer in their own cycle; PUSH answers from RESP.
  always_comb begin
    done_s   = 1'b0;
    result_s = 32'd0;
    if (!reset && (state_q == RESP)) begin
      done_s   = 1'b1;
      result_s = acc_q;
    end else if (accept_s && (op_s != OP_PUSH)) begin
      done_s = 1'b1;
      if (op_s == OP_STATUS) begin
        result_s = {16'(row_q), 16'(col_q)};
      end else begin
        result_s = 32'd0;
      end
    end else begin
      done_s   = 1'b0;
      result_s = 32'd0;
    end
  end

  assign ci.done   = done_s;
  assign ci.result = result_s;

  // Control and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pix_q   <= 2'd0;
      data_q  <= 32'd0;
      acc_q   <= 32'd0;
      thr_q   <= 8'd0;
      width_q <= WIDTH_MAX;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      thr_q   <= thr_d;
      width_q <= width_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
    end
  end

  // Line buffers: each column moves down one line as the new pixel lands.
  always_ff @(posedge clock) begin
    if (!reset && (state_q == BUSY)) begin
      line_b_q[addr_s] <= la_s;
      line_a_q[addr_s] <= pix_s;
    end
  end
endmodule

// File: tb/tb_sobel_stream_ci.sv
// Scoreboard bench for sobel_stream_ci: an image-level reference model fills
// an expected-response queue that a negedge monitor drains on every done.
module tb_sobel_stream_ci;
  localparam int         MAXW  = 640;
  localparam logic [7:0] CI_ID = 8'd0;
  localparam logic [1:0] OP_CONFIG = 2'b00, OP_PUSH = 2'b01, OP_STATUS = 2'b10, OP_CLEAR = 2'b11;

  logic clock = 1'b0;
  logic reset;
  sobel_stream_ci_if bus();

  sobel_stream_ci #(.customInstructionId(CI_ID), .MAX_WIDTH(MAXW), .CNT_W(16)) dut (
    .clock(clock),
    .reset(reset),
    .ci   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: image rows (mod 3) plus position, threshold and width.
  int m_col, m_row, m_thr, m_width;
  int img [3][MAXW];

  task automatic model_reset();
    m_col = 0; m_row = 0; m_thr = 0; m_width = MAXW;
  endtask

  function automatic int pxat(int dr, int c);
    return img[(m_row - 2 + dr) % 3][c];
  endfunction

  task automatic model_push(input logic [31:0] a, output logic [31:0] res);
    res = 32'd0;
    for (int k = 0; k < 4; k++) begin
      int p, gx, gy, mag;
      p = (a >> (8 * k)) & 255;
      img[m_row % 3][m_col] = p;
      if (m_row >= 2 && m_col >= 2) begin
        gx = (pxat(0, m_col) + 2 * pxat(1, m_col) + pxat(2, m_col))
           - (pxat(0, m_col - 2) + 2 * pxat(1, m_col - 2) + pxat(2, m_col - 2));
        gy = (pxat(2, m_col - 2) + 2 * pxat(2, m_col - 1) + pxat(2, m_col))
           - (pxat(0, m_col - 2) + 2 * pxat(0, m_col - 1) + pxat(0, m_col));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > m_thr) res = res | (32'hFF << (8 * k));
      end
      m_col = m_col + 1;
      if (m_col == m_width) begin
        m_col = 0;
        if (m_row < 65535) m_row = m_row + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one accepted command; optionally override the model's answer with a
  // fixed expectation, and optionally poke a second start mid-PUSH.
  task automatic cmd(input logic [1:0] op, input logic [31:0] a, input bit use_exp,
                     input logic [31:0] exp_v, input bit poke);
    exp_t        e;
    logic [31:0] mres;
    int          enc;
    bus.start  = 1'b1;
    bus.ciN    = CI_ID;
    bus.valueA = a;
    bus.valueB = {30'($urandom), op};
    mres = 32'd0;
    case (op)
      OP_CONFIG: begin
        m_thr = a[7:0];
        enc = {a[25:18], 2'b00};
        m_width = (enc == 0 || enc > MAXW) ? MAXW : enc;
      end
      OP_PUSH:   model_push(a, mres);
      OP_STATUS: mres = {16'(m_row), 16'(m_col)};
      default: begin m_col = 0; m_row = 0; end
    endcase
    e.res = use_exp ? exp_v : mres;
    e.at  = cyc + ((op == OP_PUSH) ? 5 : 0);
    sbq.push_back(e);
    tick();
    bus.start = 1'b0;
    if (op == OP_PUSH) begin
      for (int i = 2; i <= 6; i++) begin
        tick();
        bus.start  = (poke && i == 2);
        bus.valueB = {30'($urandom), OP_STATUS};
      end
    end
  endtask

  task automatic foreign_cmd(input logic [1:0] op);
    bus.start  = 1'b1;
    bus.ciN    = CI_ID + 8'd1;
    bus.valueA = $urandom;
    bus.valueB = {30'($urandom), op};
    tick();
    bus.start = 1'b0;
    bus.ciN   = CI_ID;
  endtask

  function automatic logic [31:0] rand_pixels();
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 3))
        0:       v[8*k +: 8] = 8'h00;
        1:       v[8*k +: 8] = 8'hFF;
        default: v[8*k +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  // Monitor: pop on done, otherwise require result 0 and no overdue answer.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (bus.done) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: cycle %0d result %h, required no done", cyc, bus.result);
      end else begin
        e = sbq.pop_front();
        if (bus.result !== e.res || cyc != e.at) begin
          errors++;
          $display("FAIL done_result: got %h at cycle %0d, required %h at cycle %0d",
                   bus.result, cyc, e.res, e.at);
        end
      end
    end else begin
      checks++;
      if (bus.result !== 32'd0) begin
        errors++;
        $display("FAIL result_idle: cycle %0d result %h, required 00000000", cyc, bus.result);
      end
      if (sbq.size() != 0 && sbq[0].at <= cyc) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_done: cycle %0d done 0, required done with %h", cyc, e.res);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    reset = 1'b1;
    bus.start = 1'b0; bus.ciN = CI_ID; bus.valueA = 32'd0; bus.valueB = 32'd0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    cmd(OP_STATUS, 32'd0, 1'b1, 32'h0000_0000, 1'b0);
    cmd(OP_CONFIG, 32'h0008_0010, 1'b1, 32'h0000_0000, 1'b0);
    cmd(OP_STATUS, 32'd0, 1'b1, 32'h0000_0000, 1'b0);

    for (int i = 0; i < 6; i++) cmd(OP_PUSH, 32'h4040_4040, 1'b1, 32'h0000_0000, 1'b0);
    cmd(OP_STATUS, 32'd0, 1'b1, 32'h0003_0000, 1'b0);

    cmd(OP_CLEAR, 32'd0, 1'b1, 32'h0000_0000, 1'b0);
    for (int ln = 0; ln < 3; ln++) begin
      cmd(OP_PUSH, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
      cmd(OP_PUSH, 32'hFFFF_FFFF, 1'b1, (ln == 2) ? 32'h0000_FFFF : 32'h0000_0000, 1'b0);
    end

    cmd(OP_PUSH, rand_pixels(), 1'b0, 32'd0, 1'b1);
    cmd(OP_STATUS, 32'd0, 1'b0, 32'd0, 1'b0);

    // PUSH aborted by reset two cycles in.
    bus.start = 1'b1; bus.ciN = CI_ID; bus.valueA = $urandom; bus.valueB = {30'd0, OP_PUSH};
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    cmd(OP_STATUS, 32'd0, 1'b1, 32'h0000_0000, 1'b0);

    // Reset wins over a simultaneous CLEAR/STATUS start.
    cmd(OP_CONFIG, 32'h0008_0010, 1'b1, 32'h0000_0000, 1'b0);
    cmd(OP_PUSH, rand_pixels(), 1'b0, 32'd0, 1'b0);
    reset = 1'b1; bus.start = 1'b1; bus.valueB = {30'd0, OP_STATUS};
    tick();
    reset = 1'b0; bus.start = 1'b0;
    model_reset();
    cmd(OP_STATUS, 32'd0, 1'b1, 32'h0000_0000, 1'b0);

    cmd(OP_CONFIG, 32'h0008_0010, 1'b1, 32'h0000_0000, 1'b0);
    for (int i = 0; i < 3; i++) cmd(OP_PUSH, rand_pixels(), 1'b0, 32'd0, 1'b0);
    for (int op = 0; op < 4; op++) foreign_cmd(2'(op));
    repeat (6) tick();
    cmd(OP_STATUS, 32'd0, 1'b1, 32'h0001_0004, 1'b0);

    for (int f = 0; f < 6; f++) begin
      w = 4 * $urandom_range(1, 8);
      cmd(OP_CONFIG, {6'($urandom), 10'(w), 8'($urandom), 8'($urandom)}, 1'b0, 32'd0, 1'b0);
      cmd(OP_CLEAR, 32'd0, 1'b0, 32'd0, 1'b0);
      n = $urandom_range(4, 24);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) foreign_cmd(2'($urandom));
        cmd(OP_PUSH, rand_pixels(), 1'b0, 32'd0, 1'b0);
      end
      cmd(OP_STATUS, 32'd0, 1'b0, 32'd0, 1'b0);
    end

    // Over-range width clamps to MAX_WIDTH.
    cmd(OP_CONFIG, 32'h03FF_0020, 1'b1, 32'h0000_0000, 1'b0);
    cmd(OP_CLEAR, 32'd0, 1'b1, 32'h0000_0000, 1'b0);
    for (int i = 0; i < 161; i++) cmd(OP_PUSH, rand_pixels(), 1'b0, 32'd0, 1'b0);
    cmd(OP_STATUS, 32'd0, 1'b1, 32'h0001_0004, 1'b0);

    // Encoded width 0 (only the cleared low bits set) also loads MAX_WIDTH.
    cmd(OP_CONFIG, 32'h0003_00FF, 1'b1, 32'h0000_0000, 1'b0);
    cmd(OP_CLEAR, 32'd0, 1'b1, 32'h0000_0000, 1'b0);
    for (int i = 0; i < 160; i++) cmd(OP_PUSH, rand_pixels(), 1'b0, 32'd0, 1'b0);
    cmd(OP_STATUS, 32'd0, 1'b1, 32'h0001_0000, 1'b0);

    repeat (10) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: %0d still queued, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
